// File: rtl/dram_port_arbiter.sv
// Shares the single data-RAM port between the CPU external bus, which always wins, and a
// debug read port that borrows idle RAM cycles and returns data through a registered handshake.
module dram_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned DBG_MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_rd,
    input  logic              i_cpu_wr,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic              o_dbg_gnt,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_rvalid,
    output logic              o_dbg_busy,
    output logic              o_dbg_starved,
    output logic              o_ram_rd,
    output logic              o_ram_wr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam int unsigned      CNT_W   = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [RD_LAT-1:0]   own_vld_q, own_vld_d;
    logic [RD_LAT-1:0]   own_dbg_q, own_dbg_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;

    logic cpu_act_s;
    logic cpu_rd_s;
    logic dbg_gnt_s;
    logic ram_rd_s;
    logic dbg_ret_s;
    logic cpu_ret_s;

    // A simultaneous read+write is treated as a write only.
    assign cpu_act_s = i_cpu_rd | i_cpu_wr;
    assign cpu_rd_s  = i_cpu_rd & ~i_cpu_wr;
    assign ram_rd_s  = cpu_rd_s | dbg_gnt_s;
    assign dbg_ret_s = own_vld_q[RD_LAT-1] & own_dbg_q[RD_LAT-1];
    assign cpu_ret_s = own_vld_q[RD_LAT-1] & ~own_dbg_q[RD_LAT-1];

    // State, owner pipe and debug return registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            dbg_addr_q   <= {ADDR_W{1'b0}};
            wait_cnt_q   <= {CNT_W{1'b0}};
            own_vld_q    <= {RD_LAT{1'b0}};
            own_dbg_q    <= {RD_LAT{1'b0}};
            dbg_rdata_q  <= {DATA_W{1'b0}};
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbg_addr_q   <= dbg_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            own_vld_q    <= own_vld_d;
            own_dbg_q    <= own_dbg_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    // Debug FSM next state; IDLE during the rvalid cycle still counts as busy
    always_comb begin
        state_d    = state_q;
        dbg_addr_d = dbg_addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_dbg_req && !dbg_rvalid_q) begin
                    state_d    = S_WAIT;
                    dbg_addr_d = i_dbg_addr;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dbg_gnt_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (dbg_ret_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Debug FSM outputs: grant only in a cycle the CPU leaves the port idle
    always_comb begin
        dbg_gnt_s = 1'b0;
        case (state_q)
            S_WAIT:  dbg_gnt_s = ~cpu_act_s;
            default: dbg_gnt_s = 1'b0;
        endcase
    end

    // Starvation counter, read-owner shift register and debug data capture
    always_comb begin
        wait_cnt_d   = {CNT_W{1'b0}};
        own_vld_d    = {RD_LAT{1'b0}};
        own_dbg_d    = {RD_LAT{1'b0}};
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = dbg_ret_s;
        if (state_q == S_WAIT && !dbg_gnt_s) begin
            if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = {CNT_W{1'b0}};
        end
        own_vld_d[0] = ram_rd_s;
        own_dbg_d[0] = dbg_gnt_s;
        for (int i = 1; i < RD_LAT; i++) begin
            own_vld_d[i] = own_vld_q[i-1];
            own_dbg_d[i] = own_dbg_q[i-1];
        end
        if (dbg_ret_s) begin
            dbg_rdata_d = i_ram_rdata;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    assign o_ram_rd      = ram_rd_s;
    assign o_ram_wr      = i_cpu_wr;
    assign o_ram_addr    = dbg_gnt_s ? dbg_addr_q : i_cpu_addr;
    assign o_ram_wdata   = i_cpu_wdata;
    assign o_cpu_rdata   = i_ram_rdata;
    assign o_cpu_rvalid  = cpu_ret_s;
    assign o_dbg_gnt     = dbg_gnt_s;
    assign o_dbg_rdata   = dbg_rdata_q;
    assign o_dbg_rvalid  = dbg_rvalid_q;
    assign o_dbg_busy    = (state_q != S_IDLE) | dbg_rvalid_q;
    assign o_dbg_starved = (wait_cnt_q == CNT_MAX);

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Arbitrates the single data-RAM port between the CPU external bus (MAR/MBR path) and a user-interface debug read port, so memory contents can be inspected while the CPU runs or single-steps. The CPU has absolute priority and sees zero added latency. Debug reads use idle RAM cycles and return data through a registered handshake. The block sits between the external bus and the data RAM at CPU top level.

## Interface
- ADDR_W, 8, address width
- DATA_W, 16, data width
- RD_LAT, 1, RAM read latency in cycles (1..3), from ram_rd to valid i_ram_rdata
- DBG_MAX_WAIT, 15, debug wait-cycle count at which starvation is flagged
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_cpu_rd  in  1  CPU read strobe from external bus
- i_cpu_wr  in  1  CPU write strobe from external bus
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wdata  in  DATA_W  CPU write data
- o_cpu_rdata  out  DATA_W  CPU read data, passthrough of i_ram_rdata
- o_cpu_rvalid  out  1  CPU read data valid
- i_dbg_req  in  1  debug read request, single-cycle sample
- i_dbg_addr  in  ADDR_W  debug address, sampled with i_dbg_req
- o_dbg_gnt  out  1  debug read issued to RAM this cycle
- o_dbg_rdata  out  DATA_W  registered debug read data
- o_dbg_rvalid  out  1  one-cycle pulse: o_dbg_rdata is valid
- o_dbg_busy  out  1  debug transaction in progress
- o_dbg_starved  out  1  debug wait reached DBG_MAX_WAIT
- o_ram_rd, o_ram_wr  out  1  RAM strobes
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data

## Operation
- Debug FSM states:
  - IDLE: accepts i_dbg_req and latches i_dbg_addr, then goes to WAIT.
  - WAIT: in the first cycle with neither i_cpu_rd nor i_cpu_wr asserted, issues the debug read (o_ram_rd=1, o_ram_addr=latched address, o_dbg_gnt=1), then goes to RESP.
  - RESP: waits for the read to return, then goes to IDLE.
- CPU path is combinational and takes priority every cycle:
  - i_cpu_wr: o_ram_wr=1 with CPU address and data.
  - i_cpu_rd only: o_ram_rd=1 with CPU address.
  - i_cpu_rd and i_cpu_wr together: write only. No read is issued and no o_cpu_rvalid is produced.
- Return routing: an RD_LAT-deep owner shift register records {valid, is_dbg} per issued read.
  - A CPU-owned return drives o_cpu_rvalid=1 in the return cycle.
  - A debug-owned return is captured into o_dbg_rdata. o_dbg_rvalid pulses the next cycle, and the FSM returns to IDLE in that same cycle.
- i_dbg_req while o_dbg_busy=1 is ignored and not queued.
- Starvation counter: 0 in IDLE; increments each WAIT cycle in which the debug read is blocked by a CPU access; saturates at DBG_MAX_WAIT.
  - o_dbg_starved = (count == DBG_MAX_WAIT).
  - The counter clears on grant.
  - The flag is status only and never stalls the CPU.
- When no access is active, RAM address and data outputs default to the CPU inputs.

## Timing
- Reset values: FSM=IDLE, counter=0, owner pipe cleared, o_dbg_rdata=0. o_dbg_gnt, o_dbg_rvalid, o_dbg_busy, o_dbg_starved and o_cpu_rvalid are all 0.
- Reset mid-transaction aborts the transaction. An in-flight debug return is discarded and produces no rvalid.
- CPU access: RAM strobes in the same cycle. o_cpu_rvalid at issue+RD_LAT.
- Debug, best case (RD_LAT=1):
  - cycle 0: i_dbg_req
  - cycle 1: o_dbg_gnt
  - cycle 2: data captured
  - cycle 3: o_dbg_rvalid
- Debug, general: rvalid at grant+RD_LAT+1.
- o_dbg_busy is high from cycle 1 through the o_dbg_rvalid cycle inclusive.
- o_dbg_gnt and o_ram_rd driven by the debug path are combinational from FSM state and CPU strobes.

## Test plan
- Idle CPU, RD_LAT=1, RAM[0x10]=0xBEEF, debug req at cycle 0 -> gnt at cycle 1, o_dbg_rvalid with 0xBEEF at cycle 3, busy cycles 1-3.
- CPU reads 0x05 (=0x1234) every cycle for 6 cycles while debug waits on 0x06 -> CPU rvalid each cycle with 0x1234 and no added latency. Debug gnt in the first cycle CPU is idle.
- CPU continuously active for 20 cycles during debug WAIT, DBG_MAX_WAIT=15 -> o_dbg_starved rises after 15 blocked cycles, stays high, clears on grant.
- i_cpu_rd and i_cpu_wr together, addr 0x20, data 0xA5A5 -> write only, no o_cpu_rvalid. A debug read of 0x20 then returns 0xA5A5.
- Second i_dbg_req (addr 0x30) issued during busy -> ignored. Only the first address is read, with one rvalid pulse.
- Reset asserted the cycle after debug gnt -> no o_dbg_rvalid. All outputs return to reset values. A fresh request after release completes normally.
